// File: rtl/cpu_timer_bank_pkg.sv
// cpu_timer_pkg: register map, CTRL bit positions and channel strobe bundle for cpu_timer_bank
package cpu_timer_pkg;
  localparam int MAX_CHANNELS = 8;
  localparam logic [2:0] REG_RELOAD_LO = 3'd0;
  localparam logic [2:0] REG_RELOAD_HI = 3'd1;
  localparam logic [2:0] REG_COUNT_LO  = 3'd2;
  localparam logic [2:0] REG_COUNT_HI  = 3'd3;
  localparam logic [2:0] REG_CTRL      = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_NE       = 3;
  typedef struct packed {
    logic wr_reload_lo;
    logic wr_reload_hi;
    logic wr_ctrl;
    logic wr_status;
    logic rd_count_lo;
  } chan_strobe_t;
endpackage

// File: rtl/cpu_timer_bank_if.sv
// cpu_timer_bank_if: CPU-side access bus of the timer bank
interface cpu_timer_bank_if;
  logic       sel;
  logic       we;
  logic [5:0] addr;
  logic [7:0] di;
  logic [7:0] dout;
  modport master(output sel, we, addr, di, input dout);
  modport slave(input sel, we, addr, di, output dout);
endinterface

// File: rtl/cpu_timer_bank_channel.sv
// cpu_timer_channel: one down-counting timer with reload, control, expiry flag and count snapshot
module cpu_timer_channel
  import cpu_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_i,
  input  chan_strobe_t stb_i,
  input  logic [7:0]   di_i,
  input  logic [2:0]   reg_i,
  output logic         expire_o,
  output logic         ne_o,
  output logic         irq_o,
  output logic [7:0]   rdata_o
);
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             exp_q, exp_d;
  logic [7:0]       snap_q, snap_d;
  logic [15:0]      count_w, reload_w, reload_n;
  logic             fire;
  assign count_w  = 16'(count_q);
  assign reload_w = 16'(reload_q);
  assign fire     = tick_i & ctrl_q[CTRL_EN] & (count_q == '0);
  // a CTRL write on the expiry edge overrides everything but the EXP flag
  assign expire_o = fire & ~stb_i.wr_ctrl;
  assign ne_o     = ctrl_q[CTRL_NE];
  assign irq_o    = exp_q & ctrl_q[CTRL_IE];
  always_comb begin
    reload_n = stb_i.wr_reload_lo ? {reload_w[15:8], di_i} :
               stb_i.wr_reload_hi ? {di_i, reload_w[7:0]} : reload_w;
    reload_d = reload_n[WIDTH-1:0];
    count_d  = stb_i.wr_ctrl ? (di_i[CTRL_EN] ? reload_q : count_q) :
               fire ? (ctrl_q[CTRL_PERIODIC] ? reload_q : count_q) :
               (tick_i & ctrl_q[CTRL_EN]) ? count_q - WIDTH'(1) : count_q;
    ctrl_d   = stb_i.wr_ctrl ? di_i[3:0] :
               (fire & ~ctrl_q[CTRL_PERIODIC]) ? ctrl_q & ~(4'b1 << CTRL_EN) : ctrl_q;
    exp_d    = fire | (exp_q & ~(stb_i.wr_status & di_i[0]));
    snap_d   = stb_i.rd_count_lo ? count_w[15:8] : snap_q;
    rdata_o  = reg_i == REG_RELOAD_LO ? reload_w[7:0] :
               reg_i == REG_RELOAD_HI ? reload_w[15:8] :
               reg_i == REG_COUNT_LO  ? count_w[7:0] :
               reg_i == REG_COUNT_HI  ? snap_q :
               reg_i == REG_CTRL      ? {4'b0, ctrl_q} :
               reg_i == REG_STATUS    ? {7'b0, exp_q} : 8'h00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      exp_q    <= 1'b0;
      snap_q   <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      exp_q    <= exp_d;
      snap_q   <= snap_d;
    end
  end
endmodule

// File: rtl/cpu_timer_bank.sv
// cpu_timer_bank: CPU-programmable bank of down-counting timers driving IRQ and NMI
module cpu_timer_bank
  import cpu_timer_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  cpu_timer_bank_if.slave  bus,
  output logic             irq_n,
  output logic             nmi_n
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]       pre_q, pre_d;
  logic                tick;
  logic [2:0]          ch, rg;
  logic [7:0]          rdata [MAX_CHANNELS];
  logic [CHANNELS-1:0] irq, nmi;
  logic [7:0]          dout_q, dout_d;
  logic                nmi_n_q, nmi_n_d;
  assign {ch, rg} = bus.addr;
  assign tick     = pre_q == PW'(PRESCALE - 1);
  for (genvar i = 0; i < MAX_CHANNELS; i++) begin : g_ch
    if (i < CHANNELS) begin : g_on
      chan_strobe_t stb;
      logic         hit, expire, ne;
      assign hit = bus.sel & (ch == 3'(i));
      assign stb = '{wr_reload_lo: hit & bus.we & (rg == REG_RELOAD_LO),
                     wr_reload_hi: hit & bus.we & (rg == REG_RELOAD_HI),
                     wr_ctrl:      hit & bus.we & (rg == REG_CTRL),
                     wr_status:    hit & bus.we & (rg == REG_STATUS),
                     rd_count_lo:  hit & ~bus.we & (rg == REG_COUNT_LO)};
      cpu_timer_channel #(.WIDTH(WIDTH)) u_ch (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (tick),
        .stb_i   (stb),
        .di_i    (bus.di),
        .reg_i   (rg),
        .expire_o(expire),
        .ne_o    (ne),
        .irq_o   (irq[i]),
        .rdata_o (rdata[i])
      );
      assign nmi[i] = expire & ne;
    end else begin : g_off
      // absent channels read as zero and never decode a write
      assign rdata[i] = 8'h00;
    end
  end
  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    dout_d  = (bus.sel & ~bus.we) ? rdata[ch] : dout_q;
    nmi_n_d = ~|nmi;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      dout_q  <= '0;
      nmi_n_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      dout_q  <= dout_d;
      nmi_n_q <= nmi_n_d;
    end
  end
  assign bus.dout = dout_q;
  assign irq_n    = ~|irq;
  assign nmi_n    = nmi_n_q;
endmodule

// File: tb/tb_cpu_timer_bank.sv
// tb_cpu_timer_bank: scoreboard bench for cpu_timer_bank at PRESCALE=1 and PRESCALE=4
module tb_cpu_timer_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq_a, nmi_a, irq_b, nmi_b;
  logic rv0, rv1;
  int total = 0;
  int bad = 0;
  typedef struct {
    int         sig;
    logic [7:0] exp;
    string      name;
  } chk_t;
  chk_t rq0[$];
  chk_t rq1[$];
  chk_t sq[$];

  always #5 clk = ~clk;

  cpu_timer_bank_if ba ();
  cpu_timer_bank_if bb ();

  cpu_timer_bank #(.CHANNELS(2), .WIDTH(16), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ba), .irq_n(irq_a), .nmi_n(nmi_a));
  cpu_timer_bank #(.CHANNELS(2), .WIDTH(16), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bb), .irq_n(irq_b), .nmi_n(nmi_b));

  always @(posedge clk or posedge reset)
    if (reset) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      rv0 <= ba.sel & ~ba.we;
      rv1 <= bb.sel & ~bb.we;
    end

  function automatic logic [7:0] sig_val(int s);
    case (s)
      0: return ba.dout;
      1: return {7'b0, irq_a};
      2: return {7'b0, nmi_a};
      3: return bb.dout;
      4: return {7'b0, irq_b};
      default: return {7'b0, nmi_b};
    endcase
  endfunction

  task automatic compare(chk_t c);
    logic [7:0] v;
    v = sig_val(c.sig);
    total++;
    if (v !== c.exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", c.name, v, c.exp);
    end
  endtask

  // monitor: settles 2ns after the falling edge, then checks read data and queued probes
  initial forever begin
    @(negedge clk);
    #2;
    if (rv0) begin
      if (rq0.size() != 0) compare(rq0.pop_front());
      else begin total++; bad++; $display("FAIL dut_a read with no expectation"); end
    end
    if (rv1) begin
      if (rq1.size() != 0) compare(rq1.pop_front());
      else begin total++; bad++; $display("FAIL dut_b read with no expectation"); end
    end
    while (sq.size() != 0) compare(sq.pop_front());
  end

  task automatic acc(int d, logic w, logic [5:0] a, logic [7:0] v, logic [7:0] e, string n);
    if (d == 0) begin
      ba.sel = 1'b1; ba.we = w; ba.addr = a; ba.di = v;
      if (!w) rq0.push_back('{0, e, n});
    end else begin
      bb.sel = 1'b1; bb.we = w; bb.addr = a; bb.di = v;
      if (!w) rq1.push_back('{3, e, n});
    end
    @(negedge clk);
    ba.sel = 1'b0; ba.we = 1'b0;
    bb.sel = 1'b0; bb.we = 1'b0;
  endtask

  task automatic wr(int d, logic [5:0] a, logic [7:0] v);
    acc(d, 1'b1, a, v, 8'h00, "");
  endtask

  task automatic rd(int d, logic [5:0] a, logic [7:0] e, string n);
    acc(d, 1'b0, a, 8'h00, e, n);
  endtask

  task automatic chk(int s, logic [7:0] e, string n);
    sq.push_back('{s, e, n});
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    ba.sel = 1'b0; ba.we = 1'b0; ba.addr = '0; ba.di = '0;
    bb.sel = 1'b0; bb.we = 1'b0; bb.addr = '0; bb.di = '0;
    idle(3);
    reset = 1'b0;
    chk(1, 8'h01, "rst irq_n_a"); chk(2, 8'h01, "rst nmi_n_a"); chk(0, 8'h00, "rst dout_a");
    chk(4, 8'h01, "rst irq_n_b"); chk(5, 8'h01, "rst nmi_n_b"); chk(3, 8'h00, "rst dout_b");
    // one-shot IRQ on ch1
    wr(0, 6'h08, 8'd3); wr(0, 6'h09, 8'd0); wr(0, 6'h0C, 8'h05);
    idle(3); chk(1, 8'h01, "oneshot irq_n early");
    idle(1); chk(1, 8'h00, "oneshot irq_n fall");
    rd(0, 6'h0C, 8'h04, "oneshot ctrl en cleared");
    rd(0, 6'h0D, 8'h01, "oneshot status exp");
    idle(2); chk(0, 8'h01, "dout holds");
    wr(0, 6'h0D, 8'h01); chk(1, 8'h01, "w1c irq_n rise");
    rd(0, 6'h0D, 8'h00, "status cleared");
    // atomic count read on ch0
    wr(0, 6'h00, 8'h00); wr(0, 6'h01, 8'h01); wr(0, 6'h04, 8'h01);
    rd(0, 6'h02, 8'h00, "atomic count_lo");
    idle(2);
    rd(0, 6'h03, 8'h01, "atomic count_hi snapshot");
    wr(0, 6'h04, 8'h00);
    rd(0, 6'h02, 8'hFC, "frozen count_lo");
    rd(0, 6'h03, 8'h00, "frozen count_hi");
    // W1C on the expiry edge
    wr(0, 6'h0C, 8'h05);
    idle(3); chk(1, 8'h01, "collision irq_n early");
    wr(0, 6'h0D, 8'h01); chk(1, 8'h00, "w1c vs expiry irq_n");
    rd(0, 6'h0D, 8'h01, "w1c vs expiry exp");
    wr(0, 6'h0D, 8'h01); chk(1, 8'h01, "collision cleared");
    // CTRL write on the expiry edge
    wr(0, 6'h0C, 8'h0D);
    idle(3); chk(2, 8'h01, "ctrl collision nmi early");
    wr(0, 6'h0C, 8'h0D); chk(2, 8'h01, "ctrl wins no nmi"); chk(1, 8'h00, "ctrl wins exp set");
    idle(3); chk(2, 8'h01, "restart nmi early");
    idle(1); chk(2, 8'h00, "restart nmi pulse");
    idle(1); chk(2, 8'h01, "nmi one cycle");
    rd(0, 6'h0C, 8'h0C, "ctrl after nmi oneshot");
    wr(0, 6'h0D, 8'h01); wr(0, 6'h0C, 8'h00);
    // periodic NMI on ch0, reload 5999
    wr(0, 6'h00, 8'h6F); wr(0, 6'h01, 8'h17); wr(0, 6'h04, 8'h0B);
    idle(5999); chk(2, 8'h01, "periodic nmi early"); chk(1, 8'h01, "periodic irq_n idle");
    idle(1); chk(2, 8'h00, "periodic nmi 6000"); chk(1, 8'h01, "periodic irq_n stays");
    idle(1); chk(2, 8'h01, "periodic nmi release");
    idle(5998); chk(2, 8'h01, "periodic nmi early 2");
    idle(1); chk(2, 8'h00, "periodic nmi 12000");
    // reset mid-count with IRQ pending and dout non-zero
    wr(0, 6'h0C, 8'h05);
    idle(4); chk(1, 8'h00, "pre-reset irq_n");
    rd(0, 6'h00, 8'h6F, "pre-reset reload_lo");
    idle(1);
    reset = 1'b1;
    chk(0, 8'h00, "reset dout async"); chk(1, 8'h01, "reset irq_n async"); chk(2, 8'h01, "reset nmi_n async");
    idle(2);
    reset = 1'b0;
    idle(1); chk(2, 8'h01, "no nmi on release");
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 8; r++)
        rd(0, 6'(c * 8 + r), 8'h00, "post-reset register");
    rd(1, 6'h04, 8'h00, "post-reset ctrl_b");
    // PRESCALE=4, reload 0, periodic with NMI
    wr(1, 6'h04, 8'h0B);
    k = 0;
    while (nmi_b === 1'b1 && k < 16) begin
      idle(1);
      k++;
    end
    if (k == 16) begin
      total++; bad++;
      $display("FAIL prescale nmi timeout: got no pulse required pulse within 16 cycles");
    end
    repeat (2) begin
      idle(1); chk(5, 8'h01, "prescale nmi gap 1");
      idle(2); chk(5, 8'h01, "prescale nmi gap 3");
      idle(1); chk(5, 8'h00, "prescale nmi period 4");
    end
    rd(1, 6'h04, 8'h0B, "prescale ctrl_b");
    // out-of-range channel
    wr(1, 6'h28, 8'hAA); wr(1, 6'h2C, 8'h05);
    rd(1, 6'h28, 8'h00, "ch5 reload_lo");
    rd(1, 6'h0C, 8'h00, "ch1 ctrl untouched");
    rd(1, 6'h04, 8'h0B, "ch0 ctrl_b readback");
    rd(1, 6'h08, 8'h00, "ch1 reload untouched");
    chk(4, 8'h01, "irq_n_b idle");
    idle(3);
    if (rq0.size() + rq1.size() + sq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard drain: got %0d pending required 0", rq0.size() + rq1.size() + sq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
